// File: rtl/regfile_pkg.sv
// Shared defaults, clear-sequencer state encoding and address-width helper
// for the multiport integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int unsigned aw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: x0 check, write-first bypass, busy masking and the
// optional output register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned AW           = 5,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ready,
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] reg_data,
  input  logic            busy_bit,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  logic            hit;
  logic [XLEN-1:0] data_c;
  logic            busy_c;
  logic [XLEN-1:0] data_q;
  logic            busy_q;

  assign hit = ready && wr_en && (wr_addr == addr);

  always_comb begin
    data_c = '0;
    busy_c = 1'b0;
    if (ready && (addr != '0)) begin
      data_c = hit ? wr_data : reg_data;
      busy_c = busy_bit && !hit;
    end
  end

  // Unused (and trimmed by synthesis) when READ_LATENCY is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_c;
      busy_q <= busy_c;
    end
  end

  assign rd_data = (READ_LATENCY == 1) ? data_q : data_c;
  assign rd_busy = (READ_LATENCY == 1) ? busy_q : busy_c;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: RAM-style storage zeroed by a clear sequencer,
// one write port, NUM_RD bypassing read ports and a writeback scoreboard.
//   state | meaning
//   CLEAR | zeroing reg[clr_idx] each edge; writes/issues ignored, ready=0
//   RUN   | normal operation, ready=1
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned NREGS        = NREGS_DEF,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned READ_LATENCY = 0,
  localparam int unsigned AW          = aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd
);

  state_t            state;
  logic [AW-1:0]     clr_idx;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear sequencer and writeback.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_idx;
    mem_wd = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (wr_en && (wr_addr != '0)) begin
        mem_we = 1'b1;
        mem_wa = wr_addr;
        mem_wd = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Set after clear so a re-issue on the writeback edge stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (iss_en && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      busy <= busy_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] addr_p;
    assign addr_p = rd_addr[p*AW +: AW];

    regfile_read_port #(
      .XLEN         (XLEN),
      .AW           (AW),
      .READ_LATENCY (READ_LATENCY)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .addr     (addr_p),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .reg_data (mem[addr_p]),
      .busy_bit (busy[addr_p]),
      .rd_data  (rd_data[p*XLEN +: XLEN]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: one combinational-read and one registered-read instance
// share all inputs and are checked against hand-computed values.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_rd;

  logic        ready0, ready1;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(32), .NREGS(32), .NUM_RD(2), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .ready(ready0), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  regfile_multiport #(.XLEN(32), .NREGS(32), .NUM_RD(2), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ready(ready1), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0;
    cyc(); cyc();
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    chk("rst_data1", rd_data1[31:0], 32'd0);
    chk("rst_busy1", {30'd0, rd_busy1}, 32'd0);

    // Release reset with a write and an issue active throughout CLEAR.
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_rd = 5'd6;
    set_rd(5'd5, 5'd6);
    #1;
    for (int i = 0; i < 31; i++) begin
      chk($sformatf("clr_ready0_%0d", i), {31'd0, ready0}, 32'd0);
      chk($sformatf("clr_ready1_%0d", i), {31'd0, ready1}, 32'd0);
      chk($sformatf("clr_data0_%0d", i), rd_data0[31:0], 32'd0);
      chk($sformatf("clr_busy0_%0d", i), {30'd0, rd_busy0}, 32'd0);
      cyc();
    end
    chk("run_ready0", {31'd0, ready0}, 32'd1);
    chk("run_ready1", {31'd0, ready1}, 32'd1);
    wr_en = 1'b0; iss_en = 1'b0;

    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      chk($sformatf("sweep_p0_x%0d", a), rd_data0[31:0], 32'd0);
      chk($sformatf("sweep_p1_x%0d", 31 - a), rd_data0[63:32], 32'd0);
      chk($sformatf("sweep_busy_x%0d", a), {30'd0, rd_busy0}, 32'd0);
      cyc();
      chk($sformatf("sweep_l1_x%0d", a), rd_data1[31:0], 32'd0);
    end

    // x5 write then read back
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; set_rd(5'd1, 5'd2);
    cyc();
    wr_en = 1'b0; set_rd(5'd5, 5'd5);
    #1;
    chk("x5_l0", rd_data0[31:0], 32'hDEAD_BEEF);
    cyc();
    chk("x5_l1", rd_data1[63:32], 32'hDEAD_BEEF);

    // x0 write is dropped, including from the bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; set_rd(5'd0, 5'd0);
    #1;
    chk("x0_bypass_l0", rd_data0[31:0], 32'd0);
    cyc();
    wr_en = 1'b0;
    #1;
    chk("x0_l0", rd_data0[31:0], 32'd0);
    chk("x0_l1", rd_data1[31:0], 32'd0);

    // same-cycle write with both ports on x7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; set_rd(5'd7, 5'd7);
    #1;
    chk("byp_p0_l0", rd_data0[31:0], 32'hA5A5_A5A5);
    chk("byp_p1_l0", rd_data0[63:32], 32'hA5A5_A5A5);
    cyc();
    wr_en = 1'b0; set_rd(5'd1, 5'd1);
    #1;
    chk("byp_p0_l1", rd_data1[31:0], 32'hA5A5_A5A5);
    chk("byp_p1_l1", rd_data1[63:32], 32'hA5A5_A5A5);

    // scoreboard on x3
    iss_en = 1'b1; iss_rd = 5'd3; set_rd(5'd3, 5'd1);
    #1;
    chk("x3_busy_pre", {30'd0, rd_busy0}, 32'd0);
    cyc();
    iss_en = 1'b0;
    #1;
    chk("x3_busy_l0", {30'd0, rd_busy0}, 32'd1);
    cyc();
    chk("x3_busy_hold", {30'd0, rd_busy0}, 32'd1);
    chk("x3_busy_l1", {30'd0, rd_busy1}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
    #1;
    chk("x3_wb_busy", {30'd0, rd_busy0}, 32'd0);
    chk("x3_wb_data", rd_data0[31:0], 32'h0000_0033);
    cyc();
    wr_en = 1'b0;
    #1;
    chk("x3_after_busy_l0", {30'd0, rd_busy0}, 32'd0);
    chk("x3_after_busy_l1", {30'd0, rd_busy1}, 32'd0);
    chk("x3_after_data_l1", rd_data1[31:0], 32'h0000_0033);

    // issue and writeback to x9 on the same edge: set wins
    iss_en = 1'b1; iss_rd = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    set_rd(5'd9, 5'd9);
    cyc();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("x9_busy", {30'd0, rd_busy0}, 32'd3);
    chk("x9_data", rd_data0[63:32], 32'h99);

    // issue to x0 never marks busy
    iss_en = 1'b1; iss_rd = 5'd0; set_rd(5'd0, 5'd9);
    cyc();
    iss_en = 1'b0;
    #1;
    chk("x0_busy", {30'd0, rd_busy0}, 32'd2);

    // reset in RUN with x4 busy and holding 0x55
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55; set_rd(5'd4, 5'd4);
    cyc();
    wr_en = 1'b0; iss_en = 1'b1; iss_rd = 5'd4;
    cyc();
    iss_en = 1'b0;
    #1;
    chk("x4_pre_busy", {30'd0, rd_busy0}, 32'd3);
    chk("x4_pre_data", rd_data0[31:0], 32'h55);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rerst_ready", {31'd0, ready0}, 32'd0);
    chk("rerst_busy", {30'd0, rd_busy0}, 32'd0);
    chk("rerst_busy_l1", {30'd0, rd_busy1}, 32'd0);
    for (int i = 0; i < 31; i++) begin
      chk($sformatf("reclr_ready_%0d", i), {31'd0, ready0}, 32'd0);
      cyc();
    end
    chk("reclr_done0", {31'd0, ready0}, 32'd1);
    chk("reclr_done1", {31'd0, ready1}, 32'd1);
    chk("x4_cleared_l0", rd_data0[31:0], 32'd0);
    chk("x4_notbusy_l0", {30'd0, rd_busy0}, 32'd0);
    cyc();
    chk("x4_cleared_l1", rd_data1[31:0], 32'd0);
    chk("x9_cleared_busy", {30'd0, rd_busy1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
